// File: rtl/memory_arbiter_if.sv
// Client and backing-memory signal bundle for memory_arbiter.
// The arbiter uses the slave view; the surrounding system drives the master view.
interface memory_arbiter_if;
    logic        IReadEnable;
    logic [31:0] IAddress;
    logic        IAck;
    logic [31:0] IData;

    logic        DReadEnable;
    logic        DWriteEnable;
    logic [31:0] DAddress;
    logic [31:0] DWriteData;
    logic [3:0]  DByteEnable;
    logic        DAck;
    logic [31:0] DReadData;

    logic        BusError;

    logic        MemReq;
    logic        MemWrite;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic [3:0]  MemByteEnable;
    logic        MemReady;
    logic [31:0] MemReadData;

    modport slave (
        input  IReadEnable, IAddress,
        input  DReadEnable, DWriteEnable, DAddress, DWriteData, DByteEnable,
        input  MemReady, MemReadData,
        output IAck, IData, DAck, DReadData, BusError,
        output MemReq, MemWrite, MemAddress, MemWriteData, MemByteEnable
    );

    modport master (
        output IReadEnable, IAddress,
        output DReadEnable, DWriteEnable, DAddress, DWriteData, DByteEnable,
        output MemReady, MemReadData,
        input  IAck, IData, DAck, DReadData, BusError,
        input  MemReq, MemWrite, MemAddress, MemWriteData, MemByteEnable
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-client (instruction fetch / data) arbiter for one backing memory port,
// with round-robin tie-break and a bounded wait for memory completion.
module memory_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            CLK,
    input  logic            RST,
    memory_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Last counter value at which a still-missing MemReady becomes a timeout.
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_r;
    state_t      state_next_s;

    logic        d_req_s;
    logic        grant_s;
    logic        grant_d_s;
    logic        done_s;
    logic        timeout_s;
    logic [31:0] rdata_s;

    logic        owner_d_r;
    logic        write_r;
    logic        last_d_r;
    logic        mem_req_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_be_r;
    logic [9:0]  tmo_cnt_r;
    logic        i_ack_r;
    logic        d_ack_r;
    logic        bus_err_r;
    logic [31:0] i_data_r;
    logic [31:0] d_rdata_r;

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, grant and completion decode
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        grant_d_s    = 1'b0;
        done_s       = 1'b0;
        timeout_s    = 1'b0;
        rdata_s      = 32'h0000_0000;
        d_req_s      = bus.DReadEnable | bus.DWriteEnable;
        case (state_r)
            IDLE: begin
                if (d_req_s && bus.IReadEnable) begin
                    grant_s   = 1'b1;
                    grant_d_s = ~last_d_r;
                end else if (d_req_s) begin
                    grant_s   = 1'b1;
                    grant_d_s = 1'b1;
                end else if (bus.IReadEnable) begin
                    grant_s   = 1'b1;
                    grant_d_s = 1'b0;
                end else begin
                    grant_s   = 1'b0;
                    grant_d_s = 1'b0;
                end
                if (grant_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                // A completion in the same cycle as the timeout wins.
                if (bus.MemReady) begin
                    done_s = 1'b1;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    timeout_s = 1'b1;
                end else begin
                    done_s    = 1'b0;
                    timeout_s = 1'b0;
                end
                if (done_s && !write_r) begin
                    rdata_s = bus.MemReadData;
                end else begin
                    rdata_s = 32'h0000_0000;
                end
                if (done_s || timeout_s) begin
                    state_next_s = ACK;
                end else begin
                    state_next_s = BUSY;
                end
            end
            ACK: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Request latch, memory-side outputs, timeout counter and client responses
    always_ff @(posedge CLK) begin
        if (!RST) begin
            owner_d_r   <= 1'b0;
            write_r     <= 1'b0;
            last_d_r    <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            tmo_cnt_r   <= 10'd0;
            i_ack_r     <= 1'b0;
            d_ack_r     <= 1'b0;
            bus_err_r   <= 1'b0;
            i_data_r    <= 32'h0000_0000;
            d_rdata_r   <= 32'h0000_0000;
        end else begin
            i_ack_r   <= 1'b0;
            d_ack_r   <= 1'b0;
            bus_err_r <= 1'b0;
            if (grant_s) begin
                owner_d_r <= grant_d_s;
                write_r   <= grant_d_s & bus.DWriteEnable;
                mem_req_r <= 1'b1;
                tmo_cnt_r <= 10'd0;
                if (grant_d_s) begin
                    mem_addr_r <= bus.DAddress & 32'hFFFF_FFFC;
                    if (bus.DWriteEnable) begin
                        mem_wdata_r <= bus.DWriteData;
                        mem_be_r    <= bus.DByteEnable;
                    end else begin
                        mem_wdata_r <= 32'h0000_0000;
                        mem_be_r    <= 4'b1111;
                    end
                end else begin
                    mem_addr_r  <= bus.IAddress & 32'hFFFF_FFFC;
                    mem_wdata_r <= 32'h0000_0000;
                    mem_be_r    <= 4'b1111;
                end
            end else if (done_s || timeout_s) begin
                // A timed-out transaction still counts as served for fairness.
                mem_req_r <= 1'b0;
                last_d_r  <= owner_d_r;
                bus_err_r <= timeout_s;
                if (owner_d_r) begin
                    d_ack_r   <= 1'b1;
                    d_rdata_r <= rdata_s;
                end else begin
                    i_ack_r  <= 1'b1;
                    i_data_r <= rdata_s;
                end
            end else if (state_r == BUSY) begin
                tmo_cnt_r <= tmo_cnt_r + 10'd1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
        end
    end

    assign bus.IAck          = i_ack_r;
    assign bus.IData         = i_data_r;
    assign bus.DAck          = d_ack_r;
    assign bus.DReadData     = d_rdata_r;
    assign bus.BusError      = bus_err_r;
    assign bus.MemReq        = mem_req_r;
    assign bus.MemWrite      = write_r;
    assign bus.MemAddress    = mem_addr_r;
    assign bus.MemWriteData  = mem_wdata_r;
    assign bus.MemByteEnable = mem_be_r;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized scoreboard bench for memory_arbiter: a transaction-level model
// predicts each grant, memory-side window and ack; a monitor checks every cycle.
module tb_memory_arbiter;

    localparam int TMO = 4;

    logic clk;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    memory_arbiter_if bus();

    memory_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        int          start_c;
        int          end_c;
        int          ack_c;
        bit          own_d;
        bit          wr;
        bit          err;
        bit          aband;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   mon_en = 0;

    // environment knobs
    bit i_on = 0, d_on = 0, tie_rdy = 0, drop_ok = 0;
    int gap_max = 0, lat_fix = 0;
    bit dir_i_valid = 0, dir_d_valid = 0, dir_rd_valid = 0;
    logic [31:0] dir_i_addr, dir_d_addr, dir_d_wdata, dir_rd;
    logic [3:0]  dir_d_be;
    int          dir_d_kind;

    // client and memory model state
    bit i_pend = 0, i_granted = 0, i_drop = 0;
    bit d_pend = 0, d_granted = 0, d_drop = 0, d_rd = 0, d_wr = 0;
    int i_ack_c = 0, d_ack_c = 0, i_next_c = 0, d_next_c = 0;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    bit last_d = 0;
    int next_sample = 0;
    int rdy_c = -1;
    logic [31:0] rdy_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // One clock of stimulus; the model decides grants from the arbitration rules.
    task automatic step(input bit rst_now);
        exp_t e;
        int lat, blen, kind;
        bit ie, de;
        @(posedge clk); #1;
        if (i_pend && i_granted && cyc == i_ack_c) begin
            i_pend = 0; i_next_c = cyc + int'($urandom_range(0, gap_max));
        end
        if (d_pend && d_granted && cyc == d_ack_c) begin
            d_pend = 0; d_next_c = cyc + int'($urandom_range(0, gap_max));
        end
        if (rst_now) begin
            rst = 1'b0; i_pend = 0; d_pend = 0; last_d = 0;
            next_sample = cyc + 1; rdy_c = -1;
            if (exp_q.size() > 0) begin
                exp_q[0].aband = 1; exp_q[0].end_c = cyc;
            end
        end else begin
            rst = 1'b1;
            if (!i_pend && i_on && cyc >= i_next_c) begin
                i_pend = 1; i_granted = 0; i_drop = 0;
                i_addr = dir_i_valid ? dir_i_addr : $urandom;
            end
            if (!d_pend && d_on && cyc >= d_next_c) begin
                d_pend = 1; d_granted = 0; d_drop = 0;
                kind   = dir_d_valid ? dir_d_kind : int'($urandom_range(0, 2));
                d_rd   = (kind != 1); d_wr = (kind != 0);
                d_addr  = dir_d_valid ? dir_d_addr  : $urandom;
                d_wdata = dir_d_valid ? dir_d_wdata : $urandom;
                d_be    = dir_d_valid ? dir_d_be    : 4'($urandom);
            end
        end
        ie = i_pend && !(i_granted && i_drop);
        de = d_pend && !(d_granted && d_drop);
        bus.IReadEnable  = ie;
        bus.IAddress     = ie ? i_addr : $urandom;
        bus.DReadEnable  = de && d_rd;
        bus.DWriteEnable = de && d_wr;
        bus.DAddress     = de ? d_addr  : $urandom;
        bus.DWriteData   = de ? d_wdata : $urandom;
        bus.DByteEnable  = de ? d_be    : 4'($urandom);
        bus.MemReady     = tie_rdy || (cyc == rdy_c);
        bus.MemReadData  = (cyc == rdy_c) ? rdy_data : $urandom;
        if (!rst_now && cyc >= next_sample && (ie || de)) begin
            e.own_d = de && (!ie || !last_d);
            lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 6));
            if (tie_rdy) lat = 1;
            e.err   = (lat > TMO);
            blen    = e.err ? TMO : lat;
            e.start_c = cyc + 1; e.end_c = cyc + blen; e.ack_c = cyc + blen + 1;
            e.aband = 0;
            e.wr    = e.own_d && d_wr;
            e.addr  = (e.own_d ? d_addr : i_addr) & 32'hFFFF_FFFC;
            e.be    = e.wr ? d_be : 4'hF;
            e.wdata = d_wdata;
            rdy_data = dir_rd_valid ? dir_rd : $urandom;
            rdy_c    = e.err ? -1 : cyc + lat;
            e.rdata  = (e.err || e.wr) ? 32'h0000_0000 : rdy_data;
            last_d = e.own_d;
            next_sample = e.ack_c + 1;
            if (e.own_d) begin
                d_granted = 1; d_ack_c = e.ack_c; d_drop = drop_ok && ($urandom_range(0, 1) == 1);
            end else begin
                i_granted = 1; i_ack_c = e.ack_c; i_drop = drop_ok && ($urandom_range(0, 1) == 1);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    // Scoreboard monitor: every cycle, pop on the expected ack or check the memory window.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].aband && cyc > exp_q[0].end_c)
                void'(exp_q.pop_front());
            if (exp_q.size() > 0 && !exp_q[0].aband && cyc == exp_q[0].ack_c) begin
                mon_e = exp_q.pop_front();
                chk("iack", {31'd0, bus.IAck}, {31'd0, !mon_e.own_d});
                chk("dack", {31'd0, bus.DAck}, {31'd0, mon_e.own_d});
                chk("buserr", {31'd0, bus.BusError}, {31'd0, mon_e.err});
                chk("memreq_in_ack", {31'd0, bus.MemReq}, 32'd0);
                if (mon_e.own_d) chk("dreaddata", bus.DReadData, mon_e.rdata);
                else             chk("idata", bus.IData, mon_e.rdata);
            end else begin
                chk("no_ack", {29'd0, bus.IAck, bus.DAck, bus.BusError}, 32'd0);
                if (exp_q.size() > 0 && cyc >= exp_q[0].start_c && cyc <= exp_q[0].end_c) begin
                    chk("memreq", {31'd0, bus.MemReq}, 32'd1);
                    chk("memwrite", {31'd0, bus.MemWrite}, {31'd0, exp_q[0].wr});
                    chk("memaddress", bus.MemAddress, exp_q[0].addr);
                    chk("membyteenable", {28'd0, bus.MemByteEnable}, {28'd0, exp_q[0].be});
                    if (exp_q[0].wr) chk("memwritedata", bus.MemWriteData, exp_q[0].wdata);
                end else begin
                    chk("memreq_idle", {31'd0, bus.MemReq}, 32'd0);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus.IReadEnable = 1'b0; bus.IAddress = 32'd0;
        bus.DReadEnable = 1'b0; bus.DWriteEnable = 1'b0; bus.DAddress = 32'd0;
        bus.DWriteData = 32'd0; bus.DByteEnable = 4'd0;
        bus.MemReady = 1'b0; bus.MemReadData = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_memreq", {31'd0, bus.MemReq}, 32'd0);
        chk("rst_memwrite", {31'd0, bus.MemWrite}, 32'd0);
        chk("rst_acks", {29'd0, bus.IAck, bus.DAck, bus.BusError}, 32'd0);
        chk("rst_idata", bus.IData, 32'd0);
        chk("rst_dreaddata", bus.DReadData, 32'd0);
        chk("rst_memaddress", bus.MemAddress, 32'd0);
        chk("rst_memwritedata", bus.MemWriteData, 32'd0);
        chk("rst_membyteenable", {28'd0, bus.MemByteEnable}, 32'd0);
        mon_en = 1;

        // tie right after reset: D first, then alternation, zero-wait memory
        i_on = 1; d_on = 1; lat_fix = 1;
        run(12);
        i_on = 0; d_on = 0; run(8);

        // single fetch with MemReady on the second busy cycle
        dir_i_valid = 1; dir_i_addr = 32'h0000_0046;
        dir_rd_valid = 1; dir_rd = 32'h2408_0005; lat_fix = 2;
        i_on = 1; step(1'b0); i_on = 0; run(8);
        dir_i_valid = 0; dir_rd_valid = 0;

        // byte store
        dir_d_valid = 1; dir_d_kind = 1; dir_d_addr = 32'h0000_1003;
        dir_d_wdata = 32'hAB00_0000; dir_d_be = 4'b1000; lat_fix = 1;
        d_on = 1; step(1'b0); d_on = 0; run(8);

        // load that times out, then one completing on the last allowed cycle
        dir_d_kind = 0; dir_d_addr = 32'h0000_2000;
        lat_fix = 6; d_on = 1; step(1'b0); d_on = 0; run(8);
        lat_fix = 4; d_on = 1; step(1'b0); d_on = 0; run(8);
        dir_d_valid = 0;

        // MemReady tied high: back-to-back fetches every 3 cycles
        tie_rdy = 1; i_on = 1; run(12);
        i_on = 0; run(6); tie_rdy = 0;

        // reset during the second busy cycle, then a normal fetch
        lat_fix = 6; i_on = 1; step(1'b0); i_on = 0;
        step(1'b0); step(1'b1); run(4);
        lat_fix = 2; i_on = 1; step(1'b0); i_on = 0; run(8);

        // random traffic with drops, mixed latencies and timeouts
        lat_fix = 0; gap_max = 3; drop_ok = 1; i_on = 1; d_on = 1;
        run(600);
        i_on = 0; d_on = 0; run(10);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of cycles to wait for MemReady before aborting a transaction (range 1..1023).
REQ-002 The clock and reset SHALL be one clock and a synchronous, active-low reset, on the ports CLK and RST.
REQ-003 CLK  in  1  sole clock; all state changes on the rising edge.
REQ-004 RST  in  1  synchronous active-low reset.
REQ-005 IReadEnable  in  1  instruction fetch request; held high until IAck.
REQ-006 IAddress  in  32  fetch byte address.
REQ-007 IAck  out  1  one-cycle fetch completion pulse.
REQ-008 IData  out  32  fetched word; valid while IAck=1.
REQ-009 DReadEnable  in  1  data load request; held until DAck.
REQ-010 DWriteEnable  in  1  data store request; held until DAck.
REQ-011 DAddress  in  32  data byte address.
REQ-012 DWriteData  in  32  store data.
REQ-013 DByteEnable  in  4  store byte lanes.
REQ-014 DAck  out  1  one-cycle data completion pulse.
REQ-015 DReadData  out  32  load word; valid while DAck=1.
REQ-016 BusError  out  1  one-cycle pulse, coincident with the IAck or DAck of a timed-out transaction.
REQ-017 MemReq  out  1  backing-memory request.
REQ-018 MemWrite  out  1  1 = store, 0 = read.
REQ-019 MemAddress  out  32  word address; bits [1:0] forced to 0.
REQ-020 MemWriteData  out  32  store data.
REQ-021 MemByteEnable  out  4  lanes; 4'b1111 on reads.
REQ-022 MemReady  in  1  memory completion; MemReadData valid in the same cycle.
REQ-023 MemReadData  in  32  read return word.

Function
REQ-024 The FSM SHALL have three states: IDLE, BUSY and ACK.
REQ-025 In IDLE, requests are sampled as follows.
- The D side requests when DReadEnable or DWriteEnable is high.
- If only one side requests, it is granted.
- If both sides request, the side not served last is granted (round-robin flag LastD; reset value 0, so D wins the first tie).
REQ-026 On grant the block SHALL latch the request and enter BUSY on the next edge.
- Latched fields: owner, write flag, address, data and byte enables.
- The write flag is DWriteEnable; a store takes precedence if both D enables are high.
- Mem* outputs are driven only from these latched registers, never combinationally from the request inputs.
REQ-027 In BUSY, MemReq=1 and the Mem* outputs SHALL hold stable every cycle until MemReady=1 is sampled.
REQ-028 When MemReady=1 is sampled in BUSY, the block SHALL:
- capture MemReadData (reads only);
- update LastD;
- deassert MemReq from the next cycle;
- enter ACK.
REQ-029 In ACK, exactly one cycle, the owner's ack SHALL be 1, with IData or DReadData equal to the captured word; the next state is IDLE unconditionally.
REQ-030 In ACK, no request is sampled; minimum spacing between consecutive grants is 3 cycles (IDLE, BUSY, ACK).
REQ-031 Timeout counter rules:
- 10-bit counter, cleared on entering BUSY, incremented each BUSY cycle with MemReady=0.
- When it reaches TIMEOUT_CYCLES, the block SHALL leave BUSY for ACK with BusError=1 and read data 32'h0000_0000.
- A MemReady arriving in that same cycle SHALL win: normal completion, no BusError.
REQ-032 On a store ack, DReadData SHALL be 32'h0000_0000.
REQ-033 A request that drops its enable before its ack SHALL still complete on memory; its ack SHALL still pulse.
REQ-034 Minimum round-trip latency: request seen in IDLE at cycle t, MemReq at t+1, MemReady at t+1, ack at t+2.

Reset
REQ-035 While RST=0 at an edge, the block SHALL enter IDLE with the following values:
- MemReq=0, MemWrite=0, IAck=0, DAck=0, BusError=0;
- IData, DReadData, MemAddress, MemWriteData = 0; MemByteEnable=4'b0000;
- LastD=0; timeout counter = 0.
REQ-036 Reset mid-BUSY SHALL abandon the transaction: no ack is produced, and MemReq=0 from the first cycle after the reset edge.

Verification
REQ-037 Fetch only: IReadEnable=1, IAddress=32'h0000_0046, MemReady at 2nd BUSY cycle with 32'h2408_0005 -> MemAddress=32'h0000_0044, MemByteEnable=4'hF, IAck one cycle with IData=32'h2408_0005.
REQ-038 Tie: I and D requests in the same cycle after reset -> D granted first; with both enables re-raised after the ack, I granted next; alternation continues.
REQ-039 Store: DWriteEnable=1, DAddress=32'h0000_1003, DByteEnable=4'b1000, DWriteData=32'hAB00_0000 -> MemWrite=1, MemAddress=32'h0000_1000, lanes/data passed through, DAck with DReadData=0.
REQ-040 Timeout: TIMEOUT_CYCLES=4, MemReady held 0 -> DAck and BusError together after 4 BUSY cycles, DReadData=0; also check that MemReady in the 4th cycle yields no BusError.
REQ-041 Reset mid-BUSY: RST=0 in cycle 2 of BUSY -> no ack, MemReq=0 next cycle; a new request after release is served normally.
REQ-042 Zero-wait memory with MemReady tied 1 -> ack exactly 2 cycles after the request cycle; back-to-back requests are granted every 3 cycles.
